mac_operand_feeder: RTL

Operand sequencer on the input side of the convolution MAC. It holds one kernel (weights) and one image window (pixels) in local register buffers. On start, it streams TAPS operand pairs into the MAC, one pair per cycle. It then waits out the MAC pipeline latency and captures the accumulated result. It sits between the line-buffer/weight-load logic and the MAC datapath, and it owns the MAC's enable and accumulator-clear timing.

---
 rtl/cnn_pkg.sv | 21 ++
 rtl/tap_buffer.sv | 31 +++
 rtl/mac_operand_feeder.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
// Shared constants and encodings for the convolution MAC front end.
// Default geometry is a 3x3 kernel of 8-bit operands with a 19-bit result.
package cnn_pkg;

    localparam int DATA_W  = 8;
    localparam int TAPS    = 9;
    localparam int ADDR_W  = 4;
    localparam int RES_W   = 19;
    localparam int RES_LAT = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_STREAM  = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_CAPTURE = 2'd3
    } feeder_state_e;

    localparam logic SEL_WGT = 1'b0;
    localparam logic SEL_PIX = 1'b1;

endpackage

// File: rtl/tap_buffer.sv
// DEPTH x DATA_W register file: one synchronous write port and one
// combinational read port. Async active-low clear empties every entry.
module tap_buffer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 9,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/mac_operand_feeder.sv
// Streams one window of pixel/weight pairs into the MAC, waits out the MAC
// latency, then captures the accumulated result. RES_LAT must be at least 1.
module mac_operand_feeder #(
    parameter int DATA_W  = cnn_pkg::DATA_W,
    parameter int TAPS    = cnn_pkg::TAPS,
    parameter int ADDR_W  = cnn_pkg::ADDR_W,
    parameter int RES_W   = cnn_pkg::RES_W,
    parameter int RES_LAT = cnn_pkg::RES_LAT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic              load_sel,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic              start,
    output logic              busy,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out,
    output logic              mac_en,
    output logic              acc_clr,
    output logic              last_tap,
    input  logic [RES_W-1:0]  result_in,
    output logic [RES_W-1:0]  result_out,
    output logic              result_valid
);

    import cnn_pkg::*;

    localparam int                DRN_W      = (RES_LAT > 1) ? $clog2(RES_LAT) : 1;
    localparam logic [ADDR_W:0]   TAPS_EXT   = (ADDR_W + 1)'(TAPS);
    localparam logic [ADDR_W-1:0] LAST_TAP   = ADDR_W'(TAPS - 1);
    localparam logic [DRN_W-1:0]  DRAIN_LAST = DRN_W'(RES_LAT - 1);

    feeder_state_e     state;
    logic [ADDR_W-1:0] tap_idx;
    logic [ADDR_W-1:0] next_idx;
    logic [ADDR_W-1:0] rd_addr;
    logic [DRN_W-1:0]  drain_cnt;

    logic              wr_ok;
    logic              wr_wgt;
    logic              wr_pix;
    logic [DATA_W-1:0] wgt_rd;
    logic [DATA_W-1:0] pix_rd;
    logic [DATA_W-1:0] wgt_first;
    logic [DATA_W-1:0] pix_first;

    assign wr_ok  = load_en && (state == ST_IDLE) && ({1'b0, load_addr} < TAPS_EXT);
    assign wr_wgt = wr_ok && (load_sel == SEL_WGT);
    assign wr_pix = wr_ok && (load_sel == SEL_PIX);

    tap_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (TAPS),
        .ADDR_W (ADDR_W)
    ) u_wgt_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_wgt),
        .wr_addr (load_addr),
        .wr_data (load_data),
        .rd_addr (rd_addr),
        .rd_data (wgt_rd)
    );

    tap_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (TAPS),
        .ADDR_W (ADDR_W)
    ) u_pix_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_pix),
        .wr_addr (load_addr),
        .wr_data (load_data),
        .rd_addr (rd_addr),
        .rd_data (pix_rd)
    );

    // The read port always looks one tap ahead of the pair being presented.
    always_comb begin
        next_idx = (tap_idx == LAST_TAP) ? '0 : tap_idx + 1'b1;
        rd_addr  = (state == ST_STREAM) ? next_idx : '0;
    end

    // A load to tap 0 coinciding with start has not reached the buffer yet.
    always_comb begin
        wgt_first = (wr_wgt && (load_addr == '0)) ? load_data : wgt_rd;
        pix_first = (wr_pix && (load_addr == '0)) ? load_data : pix_rd;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            tap_idx      <= '0;
            drain_cnt    <= '0;
            a_out        <= '0;
            b_out        <= '0;
            mac_en       <= 1'b0;
            acc_clr      <= 1'b0;
            last_tap     <= 1'b0;
            busy         <= 1'b0;
            result_out   <= '0;
            result_valid <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_STREAM;
                        tap_idx  <= '0;
                        a_out    <= pix_first;
                        b_out    <= wgt_first;
                        mac_en   <= 1'b1;
                        acc_clr  <= 1'b1;
                        last_tap <= (LAST_TAP == '0);
                        busy     <= 1'b1;
                    end
                end
                ST_STREAM: begin
                    acc_clr <= 1'b0;
                    if (tap_idx == LAST_TAP) begin
                        state     <= ST_DRAIN;
                        tap_idx   <= '0;
                        drain_cnt <= '0;
                        a_out     <= '0;
                        b_out     <= '0;
                        last_tap  <= 1'b0;
                    end else begin
                        tap_idx  <= next_idx;
                        a_out    <= pix_rd;
                        b_out    <= wgt_rd;
                        last_tap <= (next_idx == LAST_TAP);
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        state  <= ST_CAPTURE;
                        mac_en <= 1'b0;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    result_out   <= result_in;
                    result_valid <= 1'b1;
                    busy         <= 1'b0;
                    drain_cnt    <= '0;
                    state        <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
